// File: rtl/bank_state_tracker.sv
// Per-rank, per-bank open-row tracker classifying user commands as HIT / EMPTY / CONFLICT.
// Optional per-bank tRAS gating is compiled in with `define TRACKER_TRAS_EN.
module bank_state_tracker #(
  parameter int NUM_RANKS      = 4,
  parameter int BANKS_PER_RANK = 8,
  parameter int ROW_BITS       = 14,
  parameter int COL_BITS       = 10,
  parameter int TRAS_CYCLES    = 15,
  localparam int RB = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1,
  localparam int BB = $clog2(BANKS_PER_RANK),
  localparam int NB = NUM_RANKS * BANKS_PER_RANK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RB-1:0]       in_rank,
  input  logic [BB-1:0]       in_bank,
  input  logic [ROW_BITS-1:0] in_row,
  input  logic [COL_BITS-1:0] in_col,
  input  logic                in_rw,
  input  logic                in_ap,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RB-1:0]       out_rank,
  output logic [BB-1:0]       out_bank,
  output logic [ROW_BITS-1:0] out_row,
  output logic [COL_BITS-1:0] out_col,
  output logic                out_rw,
  output logic                out_ap,
  output logic [1:0]          out_class,
  output logic                out_pre_ok,
  input  logic                evt_valid,
  input  logic [1:0]          evt_type,
  input  logic [RB-1:0]       evt_rank,
  input  logic [BB-1:0]       evt_bank,
  input  logic [ROW_BITS-1:0] evt_row,
  output logic [NB-1:0]       open_mask,
  output logic                err
);

  localparam int IW = $clog2(NB);
  localparam int unsigned BPR = BANKS_PER_RANK;

  typedef enum logic [1:0] {
    CLS_HIT      = 2'd0,
    CLS_EMPTY    = 2'd1,
    CLS_CONFLICT = 2'd2
  } cls_e;

  typedef enum logic [1:0] {
    EVT_ACT  = 2'd0,
    EVT_PRE  = 2'd1,
    EVT_PREA = 2'd2,
    EVT_REF  = 2'd3
  } evt_e;

  if (TRAS_CYCLES < 1) begin : g_bad_tras
    $error("TRAS_CYCLES must be at least 1");
  end

  function automatic logic [IW-1:0] bidx(input logic [RB-1:0] r, input logic [BB-1:0] b);
    logic [31:0] flat;
    flat = ((NUM_RANKS > 1) ? 32'(r) : 32'd0) * 32'(BANKS_PER_RANK) + 32'(b);
    return IW'(flat);
  endfunction

  logic                out_valid_q, out_valid_d;
  logic [RB-1:0]       out_rank_q, out_rank_d;
  logic [BB-1:0]       out_bank_q, out_bank_d;
  logic [ROW_BITS-1:0] out_row_q, out_row_d;
  logic [COL_BITS-1:0] out_col_q, out_col_d;
  logic                out_rw_q, out_rw_d;
  logic                out_ap_q, out_ap_d;

  logic [NB-1:0]       open_q, open_d;
  logic [ROW_BITS-1:0] row_q [NB];
  logic [ROW_BITS-1:0] row_d [NB];
  logic                err_q, err_d;

  logic                in_fire, out_fire, ap_fire;
  logic [IW-1:0]       out_idx, evt_idx;
  cls_e                cls;
  evt_e                evt_kind;

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign out_idx  = bidx(out_rank_q, out_bank_q);
  assign evt_idx  = bidx(evt_rank, evt_bank);
  assign evt_kind = evt_e'(evt_type);

  always_comb begin
    cls = CLS_EMPTY;
    if (open_q[out_idx]) begin
      cls = (row_q[out_idx] == out_row_q) ? CLS_HIT : CLS_CONFLICT;
    end
  end

  assign ap_fire = out_fire && out_ap_q && (cls == CLS_HIT);

`ifdef TRACKER_TRAS_EN
  localparam int CW = $clog2(TRAS_CYCLES + 1);
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  assign out_pre_ok = (cnt_q[out_idx] == '0);
`else
  assign out_pre_ok = 1'b1;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_rank_d  = out_rank_q;
    out_bank_d  = out_bank_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_rw_d    = out_rw_q;
    out_ap_d    = out_ap_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_rank_d  = in_rank;
      out_bank_d  = in_bank;
      out_row_d   = in_row;
      out_col_d   = in_col;
      out_rw_d    = in_rw;
      out_ap_d    = in_ap;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Auto-precharge is applied first so that an explicit event to the same bank overrides it.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    err_d  = err_q;
`ifdef TRACKER_TRAS_EN
    for (int unsigned i = 0; i < NB; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : cnt_q[i];
    end
`endif
    if (ap_fire) begin
      open_d[out_idx] = 1'b0;
`ifdef TRACKER_TRAS_EN
      if (cnt_q[out_idx] != '0) err_d = 1'b1;
`endif
    end
    if (evt_valid) begin
      case (evt_kind)
        EVT_ACT: begin
          if (open_q[evt_idx] && !(ap_fire && (out_idx == evt_idx))) err_d = 1'b1;
          open_d[evt_idx] = 1'b1;
          row_d[evt_idx]  = evt_row;
`ifdef TRACKER_TRAS_EN
          cnt_d[evt_idx]  = CW'(TRAS_CYCLES - 1);
`endif
        end
        EVT_PRE: begin
          open_d[evt_idx] = 1'b0;
`ifdef TRACKER_TRAS_EN
          if (cnt_q[evt_idx] != '0) err_d = 1'b1;
`endif
        end
        EVT_PREA: begin
          for (int unsigned b = 0; b < BPR; b++) begin
            open_d[bidx(evt_rank, BB'(b))] = 1'b0;
`ifdef TRACKER_TRAS_EN
            if (cnt_q[bidx(evt_rank, BB'(b))] != '0) err_d = 1'b1;
`endif
          end
        end
        EVT_REF: begin
          for (int unsigned b = 0; b < BPR; b++) begin
            if (open_q[bidx(evt_rank, BB'(b))]) err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_rank_q  <= '0;
      out_bank_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_rw_q    <= 1'b0;
      out_ap_q    <= 1'b0;
      open_q      <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
        row_q[i] <= '0;
`ifdef TRACKER_TRAS_EN
        cnt_q[i] <= '0;
`endif
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_rank_q  <= out_rank_d;
      out_bank_q  <= out_bank_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_rw_q    <= out_rw_d;
      out_ap_q    <= out_ap_d;
      open_q      <= open_d;
      err_q       <= err_d;
      for (int unsigned i = 0; i < NB; i++) begin
        row_q[i] <= row_d[i];
`ifdef TRACKER_TRAS_EN
        cnt_q[i] <= cnt_d[i];
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_rank  = out_rank_q;
  assign out_bank  = out_bank_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_rw    = out_rw_q;
  assign out_ap    = out_ap_q;
  assign out_class = cls;
  assign open_mask = open_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bank_state_tracker.sv
// Bench for bank_state_tracker: a rank/bank-array model checked every cycle, plus directed literal checks.
module tb_bank_state_tracker;

  localparam int NR = 4;
  localparam int NBK = 8;
  localparam int RW = 14;
  localparam int CWD = 10;
  localparam int TRAS = 15;

  logic clk, rst;
  logic in_valid, in_ready;
  logic [1:0] in_rank;
  logic [2:0] in_bank;
  logic [RW-1:0] in_row;
  logic [CWD-1:0] in_col;
  logic in_rw, in_ap;
  logic out_valid, out_ready;
  logic [1:0] out_rank;
  logic [2:0] out_bank;
  logic [RW-1:0] out_row;
  logic [CWD-1:0] out_col;
  logic out_rw, out_ap;
  logic [1:0] out_class;
  logic out_pre_ok;
  logic evt_valid;
  logic [1:0] evt_type;
  logic [1:0] evt_rank;
  logic [2:0] evt_bank;
  logic [RW-1:0] evt_row;
  logic [NR*NBK-1:0] open_mask;
  logic err;

  bank_state_tracker #(
    .NUM_RANKS(NR), .BANKS_PER_RANK(NBK), .ROW_BITS(RW), .COL_BITS(CWD), .TRAS_CYCLES(TRAS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rank(in_rank), .in_bank(in_bank), .in_row(in_row), .in_col(in_col),
    .in_rw(in_rw), .in_ap(in_ap),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rank(out_rank), .out_bank(out_bank), .out_row(out_row), .out_col(out_col),
    .out_rw(out_rw), .out_ap(out_ap), .out_class(out_class), .out_pre_ok(out_pre_ok),
    .evt_valid(evt_valid), .evt_type(evt_type), .evt_rank(evt_rank),
    .evt_bank(evt_bank), .evt_row(evt_row),
    .open_mask(open_mask), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit live = 0;
  bit m_valid;
  int m_r, m_b;
  logic [RW-1:0] m_rowc;
  logic [CWD-1:0] m_col;
  bit m_rw, m_ap;
  bit m_open [NR][NBK];
  logic [RW-1:0] m_row [NR][NBK];
  int m_cnt [NR][NBK];
  bit m_err;
  int m_out_count = 0;
  int n_out = 0;

  function automatic int exp_class();
    if (!m_open[m_r][m_b]) return 1;
    return (m_row[m_r][m_b] == m_rowc) ? 0 : 2;
  endfunction

  function automatic bit exp_pre_ok();
`ifdef TRACKER_TRAS_EN
    return m_cnt[m_r][m_b] == 0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin : model
    bit out_hs, in_hs, ap;
    int er, eb;
    bit n_open [NR][NBK];
    logic [RW-1:0] n_row [NR][NBK];
    int n_cnt [NR][NBK];
    if (rst) begin
      live = 1;
      m_valid = 0; m_r = 0; m_b = 0; m_rowc = '0; m_col = '0; m_rw = 0; m_ap = 0; m_err = 0;
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < NBK; b++) begin
          m_open[r][b] = 0; m_row[r][b] = '0; m_cnt[r][b] = 0;
        end
    end else begin
      out_hs = m_valid && out_ready;
      in_hs  = in_valid && (!m_valid || out_ready);
      ap     = out_hs && m_ap && (exp_class() == 0);
      n_open = m_open;
      n_row  = m_row;
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < NBK; b++)
          n_cnt[r][b] = (m_cnt[r][b] > 0) ? m_cnt[r][b] - 1 : 0;
      if (ap) begin
        n_open[m_r][m_b] = 0;
`ifdef TRACKER_TRAS_EN
        if (m_cnt[m_r][m_b] != 0) m_err = 1;
`endif
      end
      if (evt_valid) begin
        er = int'(evt_rank);
        eb = int'(evt_bank);
        case (evt_type)
          2'd0: begin
            if (m_open[er][eb] && !(ap && m_r == er && m_b == eb)) m_err = 1;
            n_open[er][eb] = 1;
            n_row[er][eb]  = evt_row;
            n_cnt[er][eb]  = TRAS - 1;
          end
          2'd1: begin
            n_open[er][eb] = 0;
`ifdef TRACKER_TRAS_EN
            if (m_cnt[er][eb] != 0) m_err = 1;
`endif
          end
          2'd2: begin
            for (int b = 0; b < NBK; b++) begin
              n_open[er][b] = 0;
`ifdef TRACKER_TRAS_EN
              if (m_cnt[er][b] != 0) m_err = 1;
`endif
            end
          end
          default: begin
            for (int b = 0; b < NBK; b++) if (m_open[er][b]) m_err = 1;
          end
        endcase
      end
      m_open = n_open;
      m_row  = n_row;
      m_cnt  = n_cnt;
      if (out_hs) m_out_count++;
      if (in_hs) begin
        m_valid = 1; m_r = int'(in_rank); m_b = int'(in_bank);
        m_rowc = in_row; m_col = in_col; m_rw = in_rw; m_ap = in_ap;
      end else if (out_hs) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] em;
    if (live) begin
      em = '0;
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < NBK; b++) em[r*NBK+b] = m_open[r][b];
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      chk("out_fields", 64'({out_rank, out_bank, out_row, out_col, out_rw, out_ap}),
          64'({2'(m_r), 3'(m_b), m_rowc, m_col, m_rw, m_ap}));
      chk("out_class", 64'(out_class), 64'(exp_class()));
      chk("open_mask", 64'(open_mask), 64'(em));
      chk("err", 64'(err), 64'(m_err));
      chk("out_pre_ok", 64'(out_pre_ok), 64'(exp_pre_ok()));
      if (out_valid && out_ready && !rst) n_out++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic send(input int r, input int b, input int row, input int col, input bit rw, input bit ap);
    in_valid = 1'b1;
    in_rank = 2'(r); in_bank = 3'(b); in_row = RW'(row); in_col = CWD'(col);
    in_rw = rw; in_ap = ap;
  endtask

  task automatic issue(input int t, input int r, input int b, input int row);
    evt_valid = 1'b1;
    evt_type = 2'(t); evt_rank = 2'(r); evt_bank = 3'(b); evt_row = RW'(row);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; in_valid = 0; in_rank = '0; in_bank = '0; in_row = '0; in_col = '0;
    in_rw = 0; in_ap = 0; out_ready = 0;
    evt_valid = 0; evt_type = '0; evt_rank = '0; evt_bank = '0; evt_row = '0;
    tick(); tick();
    rst = 0;
    probe();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_class", 64'(out_class), 64'd1);
    chk("rst_mask", 64'(open_mask), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_pre_ok", 64'(out_pre_ok), 64'd1);

    // first command goes out one cycle later as EMPTY
    send(1, 3, 'h0AB, 5, 1, 0); tick(); in_valid = 0;
    probe();
    chk("empty_valid", 64'(out_valid), 64'd1);
    chk("empty_class", 64'(out_class), 64'd1);
    chk("empty_mask", 64'(open_mask), 64'd0);

    // ACT makes the held command a HIT
    issue(0, 1, 3, 'h0AB); tick(); evt_valid = 0;
    probe();
    chk("hit_class", 64'(out_class), 64'd0);
    chk("hit_mask11", 64'(open_mask[11]), 64'd1);

    out_ready = 1; send(1, 3, 'h0AC, 6, 0, 0); tick(); in_valid = 0; out_ready = 0;
    probe();
    chk("conf_class", 64'(out_class), 64'd2);
    chk("conf_row", 64'(out_row), 64'h0AC);

    // stall for five cycles with a pending input
    send(0, 1, 'h111, 7, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); probe();
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_row", 64'(out_row), 64'h0AC);
    end
    out_ready = 1; tick();
    for (int k = 0; k < 6; k++) begin
      send(k % 4, k, 'h200 + k, k, k[0], 0); tick();
    end
    in_valid = 0; tick(); out_ready = 0;
    probe();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("stream_count", 64'(n_out), 64'd9);

    // auto-precharge HIT coinciding with an ACT to the same bank
    issue(0, 0, 2, 'h20); tick(); evt_valid = 0; idle(16);
    send(0, 2, 'h20, 1, 1, 1); tick(); in_valid = 0;
    probe();
    chk("apact_hit", 64'(out_class), 64'd0);
    out_ready = 1; issue(0, 0, 2, 'h1); tick(); out_ready = 0; evt_valid = 0;
    probe();
    chk("apact_open", 64'(open_mask[2]), 64'd1);
    chk("apact_err", 64'(err), 64'd0);
    send(0, 2, 'h1, 2, 1, 0); tick(); in_valid = 0;
    probe();
    chk("apact_row1_hit", 64'(out_class), 64'd0);

    // plain auto-precharge closes the bank
    issue(0, 3, 1, 'h55); tick(); evt_valid = 0; idle(16);
    out_ready = 1; send(3, 1, 'h55, 3, 0, 1); tick(); in_valid = 0;
    probe();
    chk("ap_hit", 64'(out_class), 64'd0);
    chk("ap_open_before", 64'(open_mask[25]), 64'd1);
    tick(); out_ready = 0;
    probe();
    chk("ap_closed", 64'(open_mask[25]), 64'd0);
    chk("ap_err", 64'(err), 64'd0);

    // PREA / PRE / REF
    issue(0, 2, 0, 'h10); tick();
    issue(0, 2, 5, 'h15); tick();
    issue(0, 2, 7, 'h17); tick(); evt_valid = 0; idle(16);
    probe();
    chk("prea_before", 64'(open_mask[23:16]), 64'hA1);
    issue(2, 2, 0, 0); tick(); evt_valid = 0;
    probe();
    chk("prea_after", 64'(open_mask[23:16]), 64'h00);
    issue(1, 0, 2, 0); tick(); evt_valid = 0;
    probe();
    chk("pre_closed", 64'(open_mask[2]), 64'd0);
    issue(1, 0, 2, 0); tick();
    issue(3, 2, 0, 0); tick(); evt_valid = 0;
    probe();
    chk("ref_clean_err", 64'(err), 64'd0);

    // ACT to an open bank is a protocol error; reset mid-operation clears everything
    issue(0, 1, 3, 'h0AB); tick(); evt_valid = 0;
    probe();
    chk("dbl_act_err", 64'(err), 64'd1);
    send(1, 3, 'h0AB, 9, 0, 0); tick(); in_valid = 0;
    rst = 1; tick(); rst = 0;
    probe();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_mask", 64'(open_mask), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    issue(0, 0, 4, 'h44); tick();
    issue(3, 0, 0, 0); tick(); evt_valid = 0;
    probe();
    chk("ref_open_err", 64'(err), 64'd1);
    rst = 1; tick(); rst = 0;

`ifdef TRACKER_TRAS_EN
    send(0, 0, 'h9, 0, 1, 0); tick(); in_valid = 0;
    issue(0, 0, 0, 'h9); tick(); evt_valid = 0;
    probe();
    chk("tras_pre_ok_0", 64'(out_pre_ok), 64'd0);
    for (int k = 1; k <= 14; k++) begin
      tick(); probe();
      chk("tras_pre_ok", 64'(out_pre_ok), 64'(k == 14));
    end
    rst = 1; tick(); rst = 0;
    issue(0, 0, 0, 'h9); tick(); evt_valid = 0; idle(9);
    issue(1, 0, 0, 0); tick(); evt_valid = 0;
    probe();
    chk("tras_early_pre_err", 64'(err), 64'd1);
    rst = 1; tick(); rst = 0;
`endif

    out_ready = 1; tick(); tick(); out_ready = 0;
    probe();
    chk("handshake_total", 64'(n_out), 64'(m_out_count));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_state_tracker.md
# bank_state_tracker

Parametrised per-rank, per-bank open-row tracker that classifies each incoming user command as row-hit, bank-empty or row-conflict before it reaches the scheduler. It generalises the single-rank bank bookkeeping to NUM_RANKS × BANKS_PER_RANK banks and adds optional per-bank tRAS gating. It sits between the user command queue and the main controller FSM. The tracker's bank table is updated from command events that the scheduler reports as issued.

## Interface
Parameters:
- NUM_RANKS, 4, number of ranks; power of two, 1 or more
- BANKS_PER_RANK, 8, banks per rank; power of two
- ROW_BITS, 14, row address width
- COL_BITS, 10, column address width
- TRAS_CYCLES, 15, minimum ACT-to-PRE spacing in clk cycles; 1 or more; used only with TRACKER_TRAS_EN

Derived widths: RB = max(1, $clog2(NUM_RANKS)); BB = $clog2(BANKS_PER_RANK).

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  user command valid
- in_ready  out  1  tracker can accept a command
- in_rank / in_bank / in_row / in_col  in  RB / BB / ROW_BITS / COL_BITS  command address fields
- in_rw  in  1  1 = read, 0 = write
- in_ap  in  1  auto-precharge requested
- out_valid  out  1  classified command valid
- out_ready  in  1  scheduler accepts the classified command
- out_rank / out_bank / out_row / out_col / out_rw / out_ap  out  same widths as inputs  registered copy of the accepted command
- out_class  out  2  0 = HIT, 1 = EMPTY, 2 = CONFLICT; 3 never produced
- out_pre_ok  out  1  target bank may be precharged now
- evt_valid  in  1  scheduler issued a command this cycle
- evt_type  in  2  0 = ACT, 1 = PRE, 2 = PREA (all banks of evt_rank), 3 = REF (treated as no-op on the table)
- evt_rank / evt_bank / evt_row  in  RB / BB / ROW_BITS  event target
- open_mask  out  NUM_RANKS*BANKS_PER_RANK  bit (r*BANKS_PER_RANK + b) = 1 when that bank is open
- err  out  1  sticky protocol error

## Operation
- Bank table: an open bit and an open-row register per bank. Reset state: all banks closed, all rows 0.
- Output stage: a single register stage.
  - in_ready = !out_valid || out_ready.
  - On an input handshake the command fields are captured and out_valid is set.
  - out_valid clears on an output handshake when no new input handshake occurs in the same cycle.
- out_class is combinational from the held command and the current table:
  - bank closed → EMPTY
  - bank open and row matches out_row → HIT
  - bank open and row differs → CONFLICT
  - The class therefore tracks table changes while the command is held.
- Event effects on the table, applied at the clock edge:
  - ACT: set the open bit and load evt_row. If the bank was already open, set err; the row is still overwritten.
  - PRE: clear the open bit. PRE to a closed bank is a silent no-op.
  - PREA: clear every bank of evt_rank.
  - REF: no table change. If any bank of evt_rank is open, set err.
- Auto-precharge: an output handshake with out_ap=1 and out_class==HIT closes the target bank at that edge.
- Simultaneous auto-precharge and event on the same bank: the explicit event wins. In particular an ACT applies without raising err.
- err clears only on rst.

## Timing
- Input-to-output latency: 1 cycle. Throughput: 1 command per cycle while out_ready is held high.
- A table update from an event or auto-precharge is visible in out_class and open_mask in the cycle after the edge. There is no same-cycle forwarding.
- Reset values:
  - out_valid = 0, all out_* fields = 0
  - out_class = EMPTY (1)
  - open_mask = 0, err = 0
  - out_pre_ok = 1
- If rst is asserted mid-operation, a held command is discarded and the whole table clears at that edge.
- Stall: while out_valid=1 and out_ready=0, in_ready is low and the held command fields stay stable.

## Configuration
- Macro `TRACKER_TRAS_EN` defined (feature compiled in):
  - Each bank has a down-counter of width $clog2(TRAS_CYCLES+1).
  - ACT loads TRAS_CYCLES-1; the counter decrements to 0 and saturates there.
  - out_pre_ok = (counter of the target bank == 0).
  - A PRE or PREA hitting a bank with a nonzero counter sets err.
  - An auto-precharge HIT handshake while the counter is nonzero also sets err.
- Macro not defined:
  - No counters are built.
  - out_pre_ok is tied to 1.
  - No tRAS-related errors are raised.

## Test plan
- Reset, then send cmd rank 1, bank 3, row 0x0AB → out_valid one cycle later with out_class = EMPTY; open_mask = 0; err = 0.
- Event ACT rank 1, bank 3, row 0x0AB, then the same command → HIT. Then row 0x0AC → CONFLICT. open_mask bit 11 = 1 (with BANKS_PER_RANK = 8).
- Hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready = 0, out fields stable. Release → one transfer per cycle with no command lost or duplicated.
- HIT command with in_ap = 1 accepted in the same cycle as an ACT event to that bank at row 0x1 → bank remains open with row 0x1; err = 0.
- With TRACKER_TRAS_EN and TRAS_CYCLES = 15: ACT, then PRE 10 cycles later → err = 1. out_pre_ok rises exactly 14 cycles after the ACT edge.
- PREA to rank 2 with banks 0, 5 and 7 open → those banks' open_mask bits clear the next cycle; a REF to rank 2 afterwards leaves err = 0.
